ifft_writeback_ctrl: RTL
========================

Name: ifft_writeback_ctrl

Overview:
- Downstream write-back stage of the conv layer AFU datapath. Sits between convLayerIFFT (cacheline_out / output_valid) and the AFU write-request channel.
- Buffers IFFT output cachelines in a FIFO and issues one write request per cacheline to consecutive cacheline addresses from a destination base.
- Counts write responses and raises done once every expected cacheline is acknowledged.
- Applies back-pressure to the IFFT pipeline.

Parameters:
ADDR_LMT, 20, cacheline address width
MDATA, 14, write request/response metadata width
CACHE_WIDTH, 512, cacheline data width
FIFO_DEPTH, 16, write-buffer depth in cachelines (power of 2, >= 8)
AF_SLACK, 4, free entries left when in_almost_full asserts

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle job start pulse
dest_base_addr  in  ADDR_LMT  destination cacheline address; sampled on start
num_cl_out  in  32  number of output cachelines in the job; sampled on start
in_valid  in  1  IFFT output cacheline valid (convLayerIFFT output_valid)
in_data  in  CACHE_WIDTH  IFFT output cacheline (cacheline_out)
in_almost_full  out  1  back-pressure to IFFT/next_ifft issue logic
wr_req_addr  out  ADDR_LMT  write request address
wr_req_mdata  out  MDATA  write request metadata (low bits of cacheline index)
wr_req_data  out  CACHE_WIDTH  write request data
wr_req_en  out  1  write request valid, one cycle per request
wr_req_almostfull  in  1  write channel back-pressure
wr_rsp0_valid  in  1  write response port 0
wr_rsp0_mdata  in  MDATA  unused except for debug
wr_rsp1_valid  in  1  write response port 1
wr_rsp1_mdata  in  MDATA  unused except for debug
done  out  1  job complete; held until next start or reset
err  out  1  sticky error flag

Behaviour:
- Reset values: all registered outputs 0 (wr_req_en, wr_req_addr, wr_req_mdata, wr_req_data, done, err, in_almost_full). State IDLE, FIFO empty, all counters 0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: on start, latch base and count, clear counters, done and err, then go to RUN. If num_cl_out == 0, go directly to DONE instead.
- RUN: push in_valid data into the FIFO.
  - Issue when all hold: FIFO non-empty, ~wr_req_almostfull, issued < num.
  - Issue actions: wr_req_en <= 1; wr_req_addr <= base + issued (mod 2^ADDR_LMT); wr_req_mdata <= issued[MDATA-1:0]; wr_req_data <= FIFO head; pop; issued++.
  - Otherwise wr_req_en <= 0.
  - When issued reaches num, wr_req_en drops the next cycle and the state moves to DRAIN.
- DRAIN: no requests issued. Go to DONE when acked == num.
- DONE: done = 1. A start pulse re-enters the IDLE start path in the same cycle, clearing done.
- Latency: in_valid in cycle c, with channel free, gives wr_req_en high in cycle c+2 at the earliest. Sustained throughput is 1 cacheline/cycle.
- Acked counter: +1 per rsp valid. Both ports valid in the same cycle gives +2. Responses are counted in RUN and DRAIN.
- FIFO boundary cases:
  - Push and pop in the same cycle: occupancy unchanged.
  - Push while full: data dropped, err <= 1.
  - Pop never occurs while empty.
- in_almost_full is registered: high when occupancy >= FIFO_DEPTH - AF_SLACK. This covers the IFFT output latency after its next is deasserted.
- err is also set by:
  - in_valid outside RUN (data discarded);
  - pushes beyond num_cl_out (data discarded);
  - a response when acked == num (excess ack).
- Reset mid-job: immediate return to IDLE, FIFO flushed, outstanding responses ignored.
- start while in RUN or DRAIN: ignored, err <= 1.
- Counters issued, acked and pushed are 32 bits wide; no wrap within a job.

Decomposition:
- Shared package (alongside complex_t in common.vh): wb_state_t enum; typedef for the cacheline type; default constants FIFO_DEPTH and AF_SLACK.
- One sub-module: sync_fifo (params WIDTH, DEPTH).
  - Ports: clk, reset, push, din, pop, dout (show-ahead), empty, full, count.
  - Reusable later for the read-response buffering.

Test Plan:
- Basic job: base=0x00100, num=4, four in_valid cycles back to back -> four wr_req_en pulses on consecutive cycles, addr 0x00100..0x00103, mdata 0..3, data in order; four acks on rsp0 -> done=1, err=0.
- Dual-port acks and zero-length job: num=2 acked in one cycle by rsp0+rsp1 -> done the next cycle. Separately, num=0 -> done=1 one cycle after start, no wr_req_en.
- Channel back-pressure: wr_req_almostfull high for 20 cycles while 12 cachelines arrive -> no requests; in_almost_full high once occupancy reaches 12. On release, 12 requests in order with no loss.
- Overflow: 17 pushes with channel blocked and FIFO_DEPTH=16 -> err=1. Subsequent requests carry only the first 16 data words.
- Address wrap: base=0xFFFFE, num=4 -> addresses 0xFFFFE, 0xFFFFF, 0x00000, 0x00001.
- Reset mid-job: reset asserted after 2 of 5 requests -> all outputs 0 the next cycle. A new start with num=3 completes normally, and late acks from the aborted job arriving before the new start are ignored.

Source files
------------

// File: rtl/ifft_writeback_ctrl_pkg.sv
// Shared types and defaults for the IFFT write-back stage of the conv layer AFU.
package ifft_writeback_ctrl_pkg;

  localparam int unsigned CL_WIDTH       = 512;
  localparam int unsigned DEF_FIFO_DEPTH = 16;
  localparam int unsigned DEF_AF_SLACK   = 4;

  typedef logic [CL_WIDTH-1:0] cacheline_t;

  typedef enum logic [1:0] {
    WB_IDLE,
    WB_RUN,
    WB_DRAIN,
    WB_DONE
  } wb_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; dout always presents the head entry while not empty.
module sync_fifo #(
  parameter  int WIDTH = 512,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // NOTE: storage has no reset; the pointers and count alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/ifft_writeback_ctrl.sv
// Buffers IFFT output cachelines and writes them to consecutive addresses, counting acks to done.
module ifft_writeback_ctrl
  import ifft_writeback_ctrl_pkg::*;
#(
  parameter int ADDR_LMT    = 20,
  parameter int MDATA       = 14,
  parameter int CACHE_WIDTH = 512,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int AF_SLACK    = DEF_AF_SLACK
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDR_LMT-1:0]    dest_base_addr,
  input  logic [31:0]            num_cl_out,
  input  logic                   in_valid,
  input  logic [CACHE_WIDTH-1:0] in_data,
  output logic                   in_almost_full,
  output logic [ADDR_LMT-1:0]    wr_req_addr,
  output logic [MDATA-1:0]       wr_req_mdata,
  output logic [CACHE_WIDTH-1:0] wr_req_data,
  output logic                   wr_req_en,
  input  logic                   wr_req_almostfull,
  input  logic                   wr_rsp0_valid,
  input  logic [MDATA-1:0]       wr_rsp0_mdata,
  input  logic                   wr_rsp1_valid,
  input  logic [MDATA-1:0]       wr_rsp1_mdata,
  output logic                   done,
  output logic                   err
);

  localparam int         CW       = $clog2(FIFO_DEPTH);
  localparam logic [CW:0] AF_LEVEL = (CW+1)'(FIFO_DEPTH - AF_SLACK);

  wb_state_t              state_q, state_d;
  logic [ADDR_LMT-1:0]    base_q, base_d;
  logic [31:0]            num_q, num_d;
  logic [31:0]            issued_q, issued_d;
  logic [31:0]            acked_q, acked_d;
  logic [31:0]            pushed_q, pushed_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   af_q, af_d;
  logic                   req_en_q, req_en_d;
  logic [ADDR_LMT-1:0]    req_addr_q, req_addr_d;
  logic [MDATA-1:0]       req_mdata_q, req_mdata_d;
  logic [CACHE_WIDTH-1:0] req_data_q, req_data_d;

  logic                   fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [CACHE_WIDTH-1:0] fifo_dout;
  logic [CW:0]            fifo_count, fifo_level;
  logic [31:0]            rsp_cnt;
  logic                   unused_rsp_mdata;

  // Response metadata is debug-only; the job is tracked purely by ack count.
  assign unused_rsp_mdata = ^{wr_rsp0_mdata, wr_rsp1_mdata};
  assign rsp_cnt          = 32'(wr_rsp0_valid) + 32'(wr_rsp1_valid);
  assign fifo_level       = fifo_count + (CW+1)'(fifo_push) - (CW+1)'(fifo_pop);
  assign af_d             = (fifo_level >= AF_LEVEL);

  sync_fifo #(
    .WIDTH (CACHE_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   (in_data),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  // NOTE: every next-state signal gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    num_d       = num_q;
    issued_d    = issued_q;
    acked_d     = acked_q;
    pushed_d    = pushed_q;
    done_d      = done_q;
    err_d       = err_q;
    req_en_d    = 1'b0;
    req_addr_d  = req_addr_q;
    req_mdata_d = req_mdata_q;
    req_data_d  = req_data_q;
    fifo_push   = 1'b0;
    fifo_pop    = 1'b0;

    if (state_q == WB_RUN || state_q == WB_DRAIN) begin
      acked_d = acked_q + rsp_cnt;
      if (acked_d > num_q) err_d = 1'b1;
      if (start)           err_d = 1'b1;
    end

    unique case (state_q)
      WB_IDLE, WB_DONE: begin
        if (state_q == WB_DONE && rsp_cnt != 32'd0) err_d = 1'b1;
        if (start) begin
          base_d   = dest_base_addr;
          num_d    = num_cl_out;
          issued_d = '0;
          acked_d  = '0;
          pushed_d = '0;
          err_d    = 1'b0;
          done_d   = (num_cl_out == 32'd0);
          state_d  = (num_cl_out == 32'd0) ? WB_DONE : WB_RUN;
        end
      end
      WB_RUN: begin
        if (in_valid) begin
          if (!fifo_full && pushed_q < num_q) begin
            fifo_push = 1'b1;
            pushed_d  = pushed_q + 32'd1;
          end else begin
            err_d = 1'b1;
          end
        end
        if (issued_q == num_q) begin
          done_d  = (acked_d >= num_q);
          state_d = (acked_d >= num_q) ? WB_DONE : WB_DRAIN;
        end else if (!fifo_empty && !wr_req_almostfull) begin
          req_en_d    = 1'b1;
          req_addr_d  = base_q + issued_q[ADDR_LMT-1:0];
          req_mdata_d = issued_q[MDATA-1:0];
          req_data_d  = fifo_dout;
          fifo_pop    = 1'b1;
          issued_d    = issued_q + 32'd1;
        end
      end
      WB_DRAIN: begin
        if (acked_d >= num_q) begin
          done_d  = 1'b1;
          state_d = WB_DONE;
        end
      end
      default: state_d = WB_IDLE;
    endcase

    // Data arriving with no job running has nowhere to go.
    if (in_valid && state_q != WB_RUN) err_d = 1'b1;
  end

  // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= WB_IDLE;
      base_q      <= '0;
      num_q       <= '0;
      issued_q    <= '0;
      acked_q     <= '0;
      pushed_q    <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      af_q        <= 1'b0;
      req_en_q    <= 1'b0;
      req_addr_q  <= '0;
      req_mdata_q <= '0;
      req_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      num_q       <= num_d;
      issued_q    <= issued_d;
      acked_q     <= acked_d;
      pushed_q    <= pushed_d;
      done_q      <= done_d;
      err_q       <= err_d;
      af_q        <= af_d;
      req_en_q    <= req_en_d;
      req_addr_q  <= req_addr_d;
      req_mdata_q <= req_mdata_d;
      req_data_q  <= req_data_d;
    end
  end

  assign in_almost_full = af_q;
  assign wr_req_en      = req_en_q;
  assign wr_req_addr    = req_addr_q;
  assign wr_req_mdata   = req_mdata_q;
  assign wr_req_data    = req_data_q;
  assign done           = done_q;
  assign err            = err_q;

endmodule
